// File: rtl/mq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mq_if
// Brief    : Multi-channel queue interface. A write port pushes into per-
//            channel TX FIFOs and a read port pops from per-channel RX FIFOs,
//            each through an IDLE/WAIT/RSP request/response handshake with
//            optional blocking wait and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mq_if #(
  parameter int DW       = 8,
  parameter int NCH      = 4,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int TMO      = 0,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_vld,
  output logic              wr_gnt,
  input  logic [CW-1:0]     wr_ch,
  input  logic              wr_wait,
  input  logic [DW-1:0]     wr_dat,
  output logic              wr_rvld,
  input  logic              wr_rgnt,
  output logic [1:0]        wr_err,
  input  logic              rd_vld,
  output logic              rd_gnt,
  input  logic [CW-1:0]     rd_ch,
  input  logic              rd_wait,
  output logic              rd_rvld,
  input  logic              rd_rgnt,
  output logic [DW-1:0]     rd_dat,
  output logic [1:0]        rd_err,
  output logic [NCH-1:0]    txq_empty_n,
  input  logic [NCH-1:0]    txq_re,
  output logic [NCH*DW-1:0] txq_dat,
  output logic [NCH-1:0]    rxq_full_n,
  input  logic [NCH-1:0]    rxq_we,
  input  logic [NCH*DW-1:0] rxq_dat
);

  // Channel selects are CW bits wide; slots beyond NCH are padded as never-ready.
  localparam int NSLOT = 1 << CW;
  localparam int TW    = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TMO > 0) ? TMO - 1 : 0);
  localparam logic [1:0] ERR_OK = 2'b00, ERR_NRDY = 2'b01, ERR_TMO = 2'b10, ERR_CH = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RSP = 2'd2} state_t;

  logic [NSLOT-1:0] w_ch_ok, w_tx_rdy, w_rx_rdy;
  logic [DW-1:0]    w_rx_head [NSLOT];
  logic [NCH-1:0]   w_tx_push, w_rx_pop;

  state_t           wr_state_q, rd_state_q;
  logic [CW-1:0]    wr_ch_q, rd_ch_q;
  logic [DW-1:0]    wr_dat_q, rd_dat_q;
  logic [1:0]       wr_err_q, rd_err_q;
  logic [TW-1:0]    wr_cnt_q, rd_cnt_q;

  // The wait flag is only consulted on acceptance; being in WAIT already encodes it.
  logic [CW-1:0] w_wr_sel, w_rd_sel;
  logic [DW-1:0] w_wr_din;
  logic          w_wr_push, w_rd_pop;

  assign w_wr_sel  = (wr_state_q == S_IDLE) ? wr_ch  : wr_ch_q;
  assign w_wr_din  = (wr_state_q == S_IDLE) ? wr_dat : wr_dat_q;
  assign w_rd_sel  = (rd_state_q == S_IDLE) ? rd_ch  : rd_ch_q;
  // One access pulse, on the edge that enters RSP with a good response.
  assign w_wr_push = (((wr_state_q == S_IDLE) & wr_vld) | (wr_state_q == S_WAIT)) & w_tx_rdy[w_wr_sel];
  assign w_rd_pop  = (((rd_state_q == S_IDLE) & rd_vld) | (rd_state_q == S_WAIT)) & w_rx_rdy[w_rd_sel];

  assign wr_gnt  = (wr_state_q == S_IDLE);
  assign wr_rvld = (wr_state_q == S_RSP);
  assign wr_err  = wr_err_q;
  assign rd_gnt  = (rd_state_q == S_IDLE);
  assign rd_rvld = (rd_state_q == S_RSP);
  assign rd_err  = rd_err_q;
  assign rd_dat  = rd_dat_q;

  // Write-path FSM: accept, optionally wait for TX room, then hold the response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state_q <= S_IDLE;
      wr_ch_q    <= '0;
      wr_dat_q   <= '0;
      wr_err_q   <= ERR_OK;
      wr_cnt_q   <= '0;
    end else begin
      case (wr_state_q)
        S_IDLE: if (wr_vld) begin
          wr_ch_q  <= wr_ch;
          wr_dat_q <= wr_dat;
          wr_cnt_q <= '0;
          if (!w_ch_ok[wr_ch]) begin
            wr_err_q <= ERR_CH;   wr_state_q <= S_RSP;
          end else if (w_tx_rdy[wr_ch]) begin
            wr_err_q <= ERR_OK;   wr_state_q <= S_RSP;
          end else if (!wr_wait) begin
            wr_err_q <= ERR_NRDY; wr_state_q <= S_RSP;
          end else begin
            wr_state_q <= S_WAIT;
          end
        end
        S_WAIT: if (w_tx_rdy[wr_ch_q]) begin
          wr_err_q <= ERR_OK;  wr_state_q <= S_RSP;
        end else if (TMO > 0) begin
          if (wr_cnt_q == TMO_LAST) begin
            wr_err_q <= ERR_TMO; wr_state_q <= S_RSP;
          end else begin
            wr_cnt_q <= wr_cnt_q + TW'(1);
          end
        end
        S_RSP: if (wr_rgnt) wr_state_q <= S_IDLE;
        default: wr_state_q <= S_IDLE;
      endcase
    end
  end

  // Read-path FSM: same flow, additionally capturing the popped head word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state_q <= S_IDLE;
      rd_ch_q    <= '0;
      rd_dat_q   <= '0;
      rd_err_q   <= ERR_OK;
      rd_cnt_q   <= '0;
    end else begin
      if (w_rd_pop) rd_dat_q <= w_rx_head[w_rd_sel];
      case (rd_state_q)
        S_IDLE: if (rd_vld) begin
          rd_ch_q  <= rd_ch;
          rd_cnt_q <= '0;
          if (!w_ch_ok[rd_ch]) begin
            rd_err_q <= ERR_CH;   rd_state_q <= S_RSP;
          end else if (w_rx_rdy[rd_ch]) begin
            rd_err_q <= ERR_OK;   rd_state_q <= S_RSP;
          end else if (!rd_wait) begin
            rd_err_q <= ERR_NRDY; rd_state_q <= S_RSP;
          end else begin
            rd_state_q <= S_WAIT;
          end
        end
        S_WAIT: if (w_rx_rdy[rd_ch_q]) begin
          rd_err_q <= ERR_OK;  rd_state_q <= S_RSP;
        end else if (TMO > 0) begin
          if (rd_cnt_q == TMO_LAST) begin
            rd_err_q <= ERR_TMO; rd_state_q <= S_RSP;
          end else begin
            rd_cnt_q <= rd_cnt_q + TW'(1);
          end
        end
        S_RSP: if (rd_rgnt) rd_state_q <= S_IDLE;
        default: rd_state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar s = NCH; s < NSLOT; s++) begin : g_pad
    assign w_ch_ok[s]   = 1'b0;
    assign w_tx_rdy[s]  = 1'b0;
    assign w_rx_rdy[s]  = 1'b0;
    assign w_rx_head[s] = '0;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

    logic [DW-1:0]  tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wp_q, tx_rp_q;
    logic [TAW:0]   tx_cnt_q, tx_cnt_d;
    logic           tx_full_n_q, tx_empty_n_q, tx_we, tx_re;

    logic [DW-1:0]  rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wp_q, rx_rp_q;
    logic [RAW:0]   rx_cnt_q, rx_cnt_d;
    logic           rx_full_n_q, rx_empty_n_q, rx_we, rx_re;

    assign w_tx_push[k] = w_wr_push & (w_wr_sel == CW'(k));
    assign w_rx_pop[k]  = w_rd_pop  & (w_rd_sel == CW'(k));

    // Pushes to a full FIFO and pops from an empty one are dropped.
    assign tx_we = w_tx_push[k] & tx_full_n_q;
    assign tx_re = txq_re[k]    & tx_empty_n_q;
    assign rx_we = rxq_we[k]    & rx_full_n_q;
    assign rx_re = w_rx_pop[k]  & rx_empty_n_q;

    assign w_ch_ok[k]   = 1'b1;
    assign w_tx_rdy[k]  = tx_full_n_q;
    assign w_rx_rdy[k]  = rx_empty_n_q;
    assign w_rx_head[k] = rx_mem[rx_rp_q];
    assign txq_empty_n[k]          = tx_empty_n_q;
    assign txq_dat[k*DW +: DW]     = tx_mem[tx_rp_q];
    assign rxq_full_n[k]           = rx_full_n_q;

    // Occupancy next-state for both FIFOs of this channel.
    always_comb begin
      tx_cnt_d = tx_cnt_q;
      if (tx_we && !tx_re)      tx_cnt_d = tx_cnt_q + (TAW+1)'(1);
      else if (!tx_we && tx_re) tx_cnt_d = tx_cnt_q - (TAW+1)'(1);
      rx_cnt_d = rx_cnt_q;
      if (rx_we && !rx_re)      rx_cnt_d = rx_cnt_q + (RAW+1)'(1);
      else if (!rx_we && rx_re) rx_cnt_d = rx_cnt_q - (RAW+1)'(1);
    end

    // Pointers, occupancy and registered full_n/empty_n flags.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
        tx_full_n_q <= 1'b1; tx_empty_n_q <= 1'b0;
        rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
        rx_full_n_q <= 1'b1; rx_empty_n_q <= 1'b0;
      end else begin
        if (tx_we) tx_wp_q <= tx_wp_q + TAW'(1);
        if (tx_re) tx_rp_q <= tx_rp_q + TAW'(1);
        tx_cnt_q     <= tx_cnt_d;
        tx_full_n_q  <= (tx_cnt_d != (TAW+1)'(TX_DEPTH));
        tx_empty_n_q <= (tx_cnt_d != '0);
        if (rx_we) rx_wp_q <= rx_wp_q + RAW'(1);
        if (rx_re) rx_rp_q <= rx_rp_q + RAW'(1);
        rx_cnt_q     <= rx_cnt_d;
        rx_full_n_q  <= (rx_cnt_d != (RAW+1)'(RX_DEPTH));
        rx_empty_n_q <= (rx_cnt_d != '0);
      end
    end

    // Storage arrays carry no reset; validity is tracked by the flags.
    always_ff @(posedge clk) begin
      if (tx_we) tx_mem[tx_wp_q] <= w_wr_din;
      if (rx_we) rx_mem[rx_wp_q] <= rxq_dat[k*DW +: DW];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mq_if
// Brief    : Self-checking bench for mq_if: directed scenarios plus random
//            traffic against per-channel queue models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mq_if;
  localparam int N = 5, DW = 8, DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // Main DUT: 5 channels (selects 5..7 are out of range), wait forever.
  logic wr_vld, wr_gnt, wr_wait, wr_rvld, wr_rgnt;
  logic rd_vld, rd_gnt, rd_wait, rd_rvld, rd_rgnt;
  logic [2:0] wr_ch, rd_ch;
  logic [7:0] wr_dat, rd_dat;
  logic [1:0] wr_err, rd_err;
  logic [N-1:0] txq_empty_n, txq_re, rxq_full_n, rxq_we;
  logic [N*DW-1:0] txq_dat, rxq_dat;

  mq_if #(.DW(DW), .NCH(N), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .TMO(0)) dut (
    .clk(clk), .rstn(rstn),
    .wr_vld(wr_vld), .wr_gnt(wr_gnt), .wr_ch(wr_ch), .wr_wait(wr_wait), .wr_dat(wr_dat),
    .wr_rvld(wr_rvld), .wr_rgnt(wr_rgnt), .wr_err(wr_err),
    .rd_vld(rd_vld), .rd_gnt(rd_gnt), .rd_ch(rd_ch), .rd_wait(rd_wait),
    .rd_rvld(rd_rvld), .rd_rgnt(rd_rgnt), .rd_dat(rd_dat), .rd_err(rd_err),
    .txq_empty_n(txq_empty_n), .txq_re(txq_re), .txq_dat(txq_dat),
    .rxq_full_n(rxq_full_n), .rxq_we(rxq_we), .rxq_dat(rxq_dat));

  // Second DUT: 4 channels, 5-cycle wait timeout.
  logic t5_wr_vld, t5_wr_gnt, t5_wr_wait, t5_wr_rvld, t5_wr_rgnt;
  logic t5_rd_vld, t5_rd_gnt, t5_rd_wait, t5_rd_rvld, t5_rd_rgnt;
  logic [1:0] t5_wr_ch, t5_rd_ch, t5_wr_err, t5_rd_err;
  logic [7:0] t5_wr_dat, t5_rd_dat;
  logic [3:0] t5_txq_empty_n, t5_txq_re, t5_rxq_full_n, t5_rxq_we;
  logic [31:0] t5_txq_dat, t5_rxq_dat;

  mq_if #(.DW(DW), .NCH(4), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .TMO(5)) dut5 (
    .clk(clk), .rstn(rstn),
    .wr_vld(t5_wr_vld), .wr_gnt(t5_wr_gnt), .wr_ch(t5_wr_ch), .wr_wait(t5_wr_wait), .wr_dat(t5_wr_dat),
    .wr_rvld(t5_wr_rvld), .wr_rgnt(t5_wr_rgnt), .wr_err(t5_wr_err),
    .rd_vld(t5_rd_vld), .rd_gnt(t5_rd_gnt), .rd_ch(t5_rd_ch), .rd_wait(t5_rd_wait),
    .rd_rvld(t5_rd_rvld), .rd_rgnt(t5_rd_rgnt), .rd_dat(t5_rd_dat), .rd_err(t5_rd_err),
    .txq_empty_n(t5_txq_empty_n), .txq_re(t5_txq_re), .txq_dat(t5_txq_dat),
    .rxq_full_n(t5_rxq_full_n), .rxq_we(t5_rxq_we), .rxq_dat(t5_rxq_dat));

  // Reference model: contents of every FIFO as a queue, plus last read data.
  logic [7:0] tx_q [N][$];
  logic [7:0] rx_q [N][$];
  logic [7:0] last_rd;
  int n_tests = 0, n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Compare every externally visible FIFO flag and TX head with the model.
  task automatic check_flags();
    logic [N-1:0] e_en, e_fn;
    logic [N*DW-1:0] e_hd, msk;
    e_en = '0; e_fn = '0; e_hd = '0; msk = '0;
    for (int k = 0; k < N; k++) begin
      if (tx_q[k].size() > 0) begin
        e_en[k] = 1'b1; e_hd[k*8 +: 8] = tx_q[k][0]; msk[k*8 +: 8] = 8'hFF;
      end
      e_fn[k] = (rx_q[k].size() < DEPTH);
    end
    check_val("txq_empty_n", txq_empty_n, e_en);
    check_val("txq_dat", txq_dat & msk, e_hd);
    check_val("rxq_full_n", rxq_full_n, e_fn);
  endtask

  task automatic ext_cycle(input logic [N-1:0] re, input logic [N-1:0] we, input logic [N*DW-1:0] d);
    txq_re = re; rxq_we = we; rxq_dat = d;
    step();
    txq_re = '0; rxq_we = '0;
    for (int k = 0; k < N; k++) begin
      if (re[k] && tx_q[k].size() > 0) void'(tx_q[k].pop_front());
      if (we[k] && rx_q[k].size() < DEPTH) rx_q[k].push_back(d[k*8 +: 8]);
    end
    check_flags();
  endtask

  // dly<0 leaves the FSM in WAIT and returns (used for the reset-abort case).
  task automatic do_write(input int ch, input bit wt, input logic [7:0] d, input int dly, input int hold);
    bit rdy; logic [1:0] e_err;
    rdy = (ch < N) && (tx_q[ch].size() < DEPTH);
    check_val("wr_gnt_idle", wr_gnt, 1);
    wr_vld = 1; wr_ch = 3'(ch); wr_wait = wt; wr_dat = d;
    step();
    wr_vld = 0; wr_ch = 3'($urandom); wr_dat = 8'($urandom); wr_wait = 1'($urandom);
    if (ch >= N) e_err = 2'b11;
    else if (rdy) e_err = 2'b00;
    else if (!wt) e_err = 2'b01;
    else begin
      check_val("wr_wait_rvld", wr_rvld, 0);
      check_val("wr_wait_gnt", wr_gnt, 0);
      if (dly < 0) return;
      repeat (dly) begin step(); check_val("wr_wait_rvld", wr_rvld, 0); end
      txq_re[ch] = 1'b1;
      step();
      txq_re = '0;
      void'(tx_q[ch].pop_front());
      check_val("wr_wait_rvld_late", wr_rvld, 0);
      step();
      e_err = 2'b00;
    end
    if (e_err == 2'b00) tx_q[ch].push_back(d);
    check_val("wr_rvld", wr_rvld, 1);
    check_val("wr_err", wr_err, e_err);
    check_flags();
    repeat (hold) begin
      step();
      check_val("wr_hold_rvld", wr_rvld, 1);
      check_val("wr_hold_err", wr_err, e_err);
    end
    wr_rgnt = 1; step(); wr_rgnt = 0;
    check_val("wr_ret_gnt", wr_gnt, 1);
    check_val("wr_ret_rvld", wr_rvld, 0);
  endtask

  task automatic do_read(input int ch, input bit wt, input int dly, input logic [7:0] pd, input int hold);
    bit rdy; logic [1:0] e_err;
    rdy = (ch < N) && (rx_q[ch].size() > 0);
    check_val("rd_gnt_idle", rd_gnt, 1);
    rd_vld = 1; rd_ch = 3'(ch); rd_wait = wt;
    step();
    rd_vld = 0; rd_ch = 3'($urandom); rd_wait = 1'($urandom);
    if (ch >= N) e_err = 2'b11;
    else if (rdy) e_err = 2'b00;
    else if (!wt) e_err = 2'b01;
    else begin
      check_val("rd_wait_rvld", rd_rvld, 0);
      repeat (dly) begin step(); check_val("rd_wait_rvld", rd_rvld, 0); end
      rxq_we[ch] = 1'b1; rxq_dat[ch*8 +: 8] = pd;
      step();
      rxq_we = '0;
      rx_q[ch].push_back(pd);
      check_val("rd_wait_rvld_late", rd_rvld, 0);
      step();
      e_err = 2'b00;
    end
    if (e_err == 2'b00) last_rd = rx_q[ch].pop_front();
    check_val("rd_rvld", rd_rvld, 1);
    check_val("rd_err", rd_err, e_err);
    check_val("rd_dat", rd_dat, last_rd);
    check_flags();
    repeat (hold) begin
      step();
      check_val("rd_hold_rvld", rd_rvld, 1);
      check_val("rd_hold_err", rd_err, e_err);
      check_val("rd_hold_dat", rd_dat, last_rd);
    end
    rd_rgnt = 1; step(); rd_rgnt = 0;
    check_val("rd_ret_gnt", rd_gnt, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn = 0; last_rd = '0;
    wr_vld = 0; wr_ch = '0; wr_wait = 0; wr_dat = '0; wr_rgnt = 0;
    rd_vld = 0; rd_ch = '0; rd_wait = 0; rd_rgnt = 0;
    txq_re = '0; rxq_we = '0; rxq_dat = '0;
    t5_wr_vld = 0; t5_wr_ch = '0; t5_wr_wait = 0; t5_wr_dat = '0; t5_wr_rgnt = 0;
    t5_rd_vld = 0; t5_rd_ch = '0; t5_rd_wait = 0; t5_rd_rgnt = 0;
    t5_txq_re = '0; t5_rxq_we = '0; t5_rxq_dat = '0;
    repeat (3) step();
    check_val("rst_wr_gnt", wr_gnt, 1);
    check_val("rst_rd_gnt", rd_gnt, 1);
    check_val("rst_rvld", {wr_rvld, rd_rvld}, 0);
    check_val("rst_err", {wr_err, rd_err}, 0);
    check_val("rst_rd_dat", rd_dat, 0);
    check_val("rst_txq_empty_n", txq_empty_n, 0);
    check_val("rst_rxq_full_n", rxq_full_n, 5'h1F);
    rstn = 1;
    repeat (2) step();

    // Single write to an empty TX channel.
    do_write(2, 0, 8'hA5, 0, 0);
    check_val("wr_ch2_head", txq_dat[23:16], 8'hA5);

    // Fill RX ch1 (plus one dropped push), fill TX ch0, then a no-wait write.
    for (int i = 0; i < DEPTH + 1; i++) ext_cycle(5'b00010, 5'b00010, {5{8'(8'h60 + i)}});
    for (int i = 0; i < DEPTH; i++) do_write(0, 0, 8'(8'h10 + i), 0, 0);
    do_write(0, 0, 8'hEE, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) ext_cycle(5'b00001, 5'b00000, '0);
    // Drain RX ch1; the first response is held 10 cycles.
    do_read(1, 0, 0, 8'h00, 10);
    for (int i = 1; i < DEPTH; i++) do_read(1, 0, 0, 8'h00, 0);
    do_read(1, 0, 0, 8'h00, 0);

    // Blocking read on empty ch3, data arrives 20 cycles after acceptance.
    do_read(3, 1, 19, 8'h3C, 0);
    // Out-of-range channels, even with wait set.
    do_write(6, 1, 8'h77, 0, 0);
    do_read(7, 1, 0, 8'h00, 0);

    // Timeout on the TMO=5 instance, then readiness coinciding with timeout.
    check_val("t5_gnt", t5_rd_gnt, 1);
    t5_rd_vld = 1; t5_rd_ch = 2'd0; t5_rd_wait = 1;
    step(); t5_rd_vld = 0;
    check_val("t5_wait_rvld", t5_rd_rvld, 0);
    n = 0;
    while (!t5_rd_rvld && n < 20) begin step(); n++; end
    check_val("t5_tmo_cycles", n, 5);
    check_val("t5_tmo_err", t5_rd_err, 2'b10);
    check_val("t5_tmo_dat", t5_rd_dat, 0);
    check_val("t5_tmo_full_n", t5_rxq_full_n, 4'hF);
    t5_rd_rgnt = 1; step(); t5_rd_rgnt = 0;
    t5_rd_vld = 1; t5_rd_ch = 2'd1; t5_rd_wait = 1;
    step(); t5_rd_vld = 0;
    repeat (3) step();
    t5_rxq_we = 4'b0010; t5_rxq_dat = 32'h0000_5A00;
    step(); t5_rxq_we = '0;
    check_val("t5_race_rvld0", t5_rd_rvld, 0);
    step();
    check_val("t5_race_rvld", t5_rd_rvld, 1);
    check_val("t5_race_err", t5_rd_err, 2'b00);
    check_val("t5_race_dat", t5_rd_dat, 8'h5A);
    t5_rd_rgnt = 1; step(); t5_rd_rgnt = 0;

    // Random traffic.
    for (int it = 0; it < 250; it++) begin
      int op, ch;
      op = $urandom_range(0, 9);
      ch = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      if (op < 4)
        do_write(ch, 1'($urandom), 8'($urandom), $urandom_range(0, 6), $urandom_range(0, 3));
      else if (op < 8)
        do_read(ch, 1'($urandom), $urandom_range(0, 6), 8'($urandom), $urandom_range(0, 3));
      else
        ext_cycle(5'($urandom), 5'($urandom), {8'($urandom), $urandom});
    end

    // Reset while the write FSM waits on a full TX ch0.
    while (tx_q[0].size() < DEPTH) do_write(0, 0, 8'($urandom), 0, 0);
    do_write(0, 1, 8'hCC, -1, 0);
    repeat (3) step();
    rstn = 0;
    #1;
    check_val("arst_wr_gnt", wr_gnt, 1);
    check_val("arst_wr_rvld", wr_rvld, 0);
    check_val("arst_rd_dat", rd_dat, 0);
    check_val("arst_txq_empty_n", txq_empty_n, 0);
    check_val("arst_rxq_full_n", rxq_full_n, 5'h1F);
    step(); step();
    rstn = 1;
    for (int k = 0; k < N; k++) begin tx_q[k].delete(); rx_q[k].delete(); end
    last_rd = '0;
    repeat (4) begin
      step();
      check_val("post_rst_gnt", wr_gnt, 1);
      check_val("post_rst_rvld", wr_rvld, 0);
      check_flags();
    end
    do_write(4, 0, 8'h42, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
